// File: rtl/l1_mem_arbiter_pkg.sv
// Shared encodings for the L1-to-memory arbiter: FSM states, owner IDs, line width.
package l1_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    WDATA = ST_WDATA
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  function automatic int line_width(input int offset_width);
    return 32 << offset_width;
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// Bundle of both L1 request/response paths and the shared memory port.
// master = arbiter view; slave = caches plus memory.
interface l1_mem_arbiter_if #(parameter int offset_width = 2);
  import l1_mem_pkg::*;
  localparam int LW = line_width(offset_width);

  logic          icache_mem_req;
  logic [31:0]   icache_mem_addr;
  logic          mem_icache_addrOK;
  logic          mem_icache_dataOK;
  logic [LW-1:0] mem_icache_rdata;

  logic          dcache_mem_req;
  logic          dcache_mem_wr;
  logic          dcache_mem_SUC;
  logic [31:0]   dcache_mem_addr;
  logic [31:0]   dcache_mem_wdata;
  logic [3:0]    dcache_mem_wstrb;
  logic          mem_dcache_addrOK;
  logic          mem_dcache_dataOK;
  logic [LW-1:0] mem_dcache_rdata;

  logic          arb_mem_req;
  logic          arb_mem_wr;
  logic          arb_mem_uncached;
  logic [31:0]   arb_mem_addr;
  logic [31:0]   arb_mem_wdata;
  logic [3:0]    arb_mem_wstrb;
  logic          mem_arb_addrOK;
  logic          mem_arb_dataOK;
  logic [LW-1:0] mem_arb_rdata;

  modport master (
    input  icache_mem_req, icache_mem_addr,
    output mem_icache_addrOK, mem_icache_dataOK, mem_icache_rdata,
    input  dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, dcache_mem_addr,
    input  dcache_mem_wdata, dcache_mem_wstrb,
    output mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_rdata,
    output arb_mem_req, arb_mem_wr, arb_mem_uncached, arb_mem_addr,
    output arb_mem_wdata, arb_mem_wstrb,
    input  mem_arb_addrOK, mem_arb_dataOK, mem_arb_rdata
  );

  modport slave (
    output icache_mem_req, icache_mem_addr,
    input  mem_icache_addrOK, mem_icache_dataOK, mem_icache_rdata,
    output dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, dcache_mem_addr,
    output dcache_mem_wdata, dcache_mem_wstrb,
    input  mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_rdata,
    input  arb_mem_req, arb_mem_wr, arb_mem_uncached, arb_mem_addr,
    input  arb_mem_wdata, arb_mem_wstrb,
    output mem_arb_addrOK, mem_arb_dataOK, mem_arb_rdata
  );

endinterface

// File: rtl/l1_mem_arbiter_rr_arb2.sv
// Two-way picker: bit0 = Icache, bit1 = Dcache; i_prio = 1 lets the Dcache win a tie.
// Purely combinational one-hot grant.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = i_prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one memory port between Icache refill and Dcache miss/write-through.
// Grant held until write addrOK or read dataOK; handshakes forwarded combinationally to the owner.
module l1_mem_arbiter
  import l1_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  l1_mem_arbiter_if.master  bus
);

  state_t     r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_prio_d, w_prio_nxt;
  logic [1:0] w_gnt;
  logic       w_is_d, w_owner_req, w_owner_wr, w_in_addr;
  logic       w_done, w_fwd_aok, w_fwd_dok;

  rr_arb2 u_rr_arb2 (
    .i_req  ({bus.dcache_mem_req, bus.icache_mem_req}),
    .i_prio (r_prio_d),
    .o_gnt  (w_gnt)
  );

  assign w_is_d      = (r_owner == OWN_D);
  assign w_owner_req = w_is_d ? bus.dcache_mem_req : bus.icache_mem_req;
  assign w_owner_wr  = w_is_d & bus.dcache_mem_wr;
  assign w_in_addr   = (r_state == ADDR);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_owner  <= OWN_D;
      r_prio_d <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_prio_d <= w_prio_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio_d;
    w_done      = 1'b0;
    w_fwd_aok   = 1'b0;
    w_fwd_dok   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_state_nxt = ADDR;
          w_owner_nxt = w_gnt[1] ? OWN_D : OWN_I;
        end
      end
      ADDR: begin
        // An abandoned request is dropped without touching the tie-break.
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
        end else if (bus.mem_arb_addrOK) begin
          w_fwd_aok = 1'b1;
          if (w_owner_wr) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else if (bus.mem_arb_dataOK) begin
            w_fwd_dok   = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WDATA;
          end
        end
      end
      WDATA: begin
        if (bus.mem_arb_dataOK) begin
          w_fwd_dok   = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_done) w_prio_nxt = (r_owner == OWN_I);
  end

  assign bus.arb_mem_req      = w_in_addr & w_owner_req;
  assign bus.arb_mem_wr       = w_in_addr & w_owner_wr;
  assign bus.arb_mem_uncached = w_in_addr & w_is_d & bus.dcache_mem_SUC;
  assign bus.arb_mem_addr     = !w_in_addr ? 32'd0 :
                                (w_is_d ? bus.dcache_mem_addr : bus.icache_mem_addr);
  assign bus.arb_mem_wdata    = (w_in_addr & w_is_d) ? bus.dcache_mem_wdata : 32'd0;
  assign bus.arb_mem_wstrb    = (w_in_addr & w_is_d) ? bus.dcache_mem_wstrb : 4'd0;

  assign bus.mem_icache_addrOK = w_fwd_aok & ~w_is_d;
  assign bus.mem_icache_dataOK = w_fwd_dok & ~w_is_d;
  assign bus.mem_dcache_addrOK = w_fwd_aok & w_is_d;
  assign bus.mem_dcache_dataOK = w_fwd_dok & w_is_d;
  assign bus.mem_icache_rdata  = bus.mem_arb_rdata;
  assign bus.mem_dcache_rdata  = bus.mem_arb_rdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: stimulus queues expected memory requests and
// L1 handshakes; a negedge monitor pops and compares whenever the DUT presents one.
module tb_l1_mem_arbiter;

  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;
  localparam logic K_AOK = 1'b0;
  localparam logic K_DOK = 1'b1;

  typedef struct packed {
    logic        wr;
    logic        unc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  typedef struct packed {
    logic         port;
    logic         kind;
    logic [127:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_bad = 0;
  mreq_t exp_req_q[$];
  rsp_t  exp_rsp_q[$];
  logic  prev_req = 1'b0;

  l1_mem_arbiter_if #(.offset_width(2)) bus ();

  l1_mem_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic mreq_t mk_req(input logic wr, input logic unc, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wstrb);
    mreq_t r;
    r.wr = wr; r.unc = unc; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    return r;
  endfunction

  function automatic rsp_t mk_rsp(input logic port, input logic kind, input logic [127:0] data);
    rsp_t r;
    r.port = port; r.kind = kind; r.data = data;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_rsp(input logic port, input logic kind, input logic [127:0] data);
    rsp_t e;
    n_chk++;
    if (exp_rsp_q.size() == 0) begin
      n_bad++;
      $display("FAIL rsp_unexpected port=%0d kind=%0d t=%0t", port, kind, $time);
    end else begin
      e = exp_rsp_q.pop_front();
      if (e.port !== port || e.kind !== kind || (kind == K_DOK && e.data !== data)) begin
        n_bad++;
        $display("FAIL rsp got port=%0d kind=%0d data=%h exp port=%0d kind=%0d data=%h",
                 port, kind, data, e.port, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mreq_t cur;
    mreq_t e;
    cur = mk_req(bus.arb_mem_wr, bus.arb_mem_uncached, bus.arb_mem_addr,
                 bus.arb_mem_wdata, bus.arb_mem_wstrb);
    if (bus.arb_mem_req && !prev_req) begin
      n_chk++;
      if (exp_req_q.size() == 0) begin
        n_bad++;
        $display("FAIL req_unexpected got=%h t=%0t", cur, $time);
      end else begin
        e = exp_req_q.pop_front();
        if (cur !== e) begin
          n_bad++;
          $display("FAIL req_fields got=%h exp=%h", cur, e);
        end
      end
    end
    prev_req = bus.arb_mem_req;
    if (bus.mem_icache_addrOK) chk_rsp(P_I, K_AOK, bus.mem_icache_rdata);
    if (bus.mem_icache_dataOK) chk_rsp(P_I, K_DOK, bus.mem_icache_rdata);
    if (bus.mem_dcache_addrOK) chk_rsp(P_D, K_AOK, bus.mem_dcache_rdata);
    if (bus.mem_dcache_dataOK) chk_rsp(P_D, K_DOK, bus.mem_dcache_rdata);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered in the IDLE cycle the grant is decided; returns in the following IDLE cycle.
  task automatic mem_read(input int a, input int b, input logic [127:0] d);
    cyc(1 + a);
    bus.mem_arb_addrOK = 1'b1;
    cyc(1);
    bus.mem_arb_addrOK = 1'b0;
    cyc(b);
    bus.mem_arb_dataOK = 1'b1;
    bus.mem_arb_rdata  = d;
    cyc(1);
    bus.mem_arb_dataOK = 1'b0;
    bus.mem_arb_rdata  = {4{32'hA5A5_5A5A}};
  endtask

  task automatic mem_read_same(input int a, input logic [127:0] d);
    cyc(1 + a);
    bus.mem_arb_addrOK = 1'b1;
    bus.mem_arb_dataOK = 1'b1;
    bus.mem_arb_rdata  = d;
    cyc(1);
    bus.mem_arb_addrOK = 1'b0;
    bus.mem_arb_dataOK = 1'b0;
    bus.mem_arb_rdata  = {4{32'hA5A5_5A5A}};
  endtask

  task automatic mem_write(input int a);
    cyc(1 + a);
    bus.mem_arb_addrOK = 1'b1;
    cyc(1);
    bus.mem_arb_addrOK = 1'b0;
  endtask

  task automatic set_d(input logic wr, input logic suc, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.dcache_mem_wr    = wr;
    bus.dcache_mem_SUC   = suc;
    bus.dcache_mem_addr  = addr;
    bus.dcache_mem_wdata = wdata;
    bus.dcache_mem_wstrb = wstrb;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, bus.arb_mem_req, 1'b0);
    chk({tag, "_wr"}, bus.arb_mem_wr, 1'b0);
    chk({tag, "_unc"}, bus.arb_mem_uncached, 1'b0);
    chk({tag, "_addr"}, bus.arb_mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.arb_mem_wdata, 32'd0);
    chk({tag, "_wstrb"}, bus.arb_mem_wstrb, 4'd0);
    chk({tag, "_i_aok"}, bus.mem_icache_addrOK, 1'b0);
    chk({tag, "_i_dok"}, bus.mem_icache_dataOK, 1'b0);
    chk({tag, "_d_aok"}, bus.mem_dcache_addrOK, 1'b0);
    chk({tag, "_d_dok"}, bus.mem_dcache_dataOK, 1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.icache_mem_req  = 1'b0;
    bus.icache_mem_addr = 32'd0;
    bus.dcache_mem_req  = 1'b0;
    set_d(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus.mem_arb_addrOK = 1'b0;
    bus.mem_arb_dataOK = 1'b0;
    bus.mem_arb_rdata  = {4{32'hA5A5_5A5A}};
    cyc(3);
    chk_all_zero("reset");
    chk("reset_rdata_follow", bus.mem_icache_rdata, {4{32'hA5A5_5A5A}});
    rstn = 1'b1;
    cyc(1);

    // Dcache write alone, addrOK three cycles after the request
    exp_req_q.push_back(mk_req(1'b1, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF));
    exp_rsp_q.push_back(mk_rsp(P_D, K_AOK, '0));
    set_d(1'b1, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    bus.dcache_mem_req = 1'b1;
    mem_write(2);
    bus.dcache_mem_req = 1'b0;
    chk("wr_idle_req", bus.arb_mem_req, 1'b0);
    cyc(1);

    // Icache read alone: addrOK at cycle 2, dataOK at cycle 6
    exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h1C00_0000, 32'd0, 4'd0));
    exp_rsp_q.push_back(mk_rsp(P_I, K_AOK, '0));
    exp_rsp_q.push_back(mk_rsp(P_I, K_DOK, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF));
    bus.icache_mem_addr = 32'h1C00_0000;
    bus.icache_mem_req  = 1'b1;
    mem_read(1, 3, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    bus.icache_mem_req = 1'b0;
    cyc(1);

    // Both held: grants alternate D, I, D, I; Icache fields are zero-forced
    set_d(1'b0, 1'b0, 32'h2000_0040, 32'hCAFE_F00D, 4'h3);
    bus.icache_mem_addr = 32'h1C00_0100;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h2000_0040, 32'hCAFE_F00D, 4'h3));
        exp_rsp_q.push_back(mk_rsp(P_D, K_AOK, '0));
        exp_rsp_q.push_back(mk_rsp(P_D, K_DOK, {4{32'h1111_0000 + 32'(k)}}));
      end else begin
        exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h1C00_0100, 32'd0, 4'd0));
        exp_rsp_q.push_back(mk_rsp(P_I, K_AOK, '0));
        exp_rsp_q.push_back(mk_rsp(P_I, K_DOK, {4{32'h1111_0000 + 32'(k)}}));
      end
    end
    bus.dcache_mem_req = 1'b1;
    bus.icache_mem_req = 1'b1;
    for (int k = 0; k < 4; k++) mem_read(k % 2, (k + 1) % 3, {4{32'h1111_0000 + 32'(k)}});
    bus.dcache_mem_req = 1'b0;
    bus.icache_mem_req = 1'b0;
    cyc(1);

    // Uncached Dcache read
    exp_req_q.push_back(mk_req(1'b0, 1'b1, 32'h1FC0_0010, 32'hCAFE_F00D, 4'h3));
    exp_rsp_q.push_back(mk_rsp(P_D, K_AOK, '0));
    exp_rsp_q.push_back(mk_rsp(P_D, K_DOK, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF));
    set_d(1'b0, 1'b1, 32'h1FC0_0010, 32'hCAFE_F00D, 4'h3);
    bus.dcache_mem_req = 1'b1;
    mem_read(0, 2, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF);
    bus.dcache_mem_req = 1'b0;
    cyc(1);

    // Owner abandons in ADDR; stray handshakes in IDLE; tie then goes to I
    exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h3000_0000, 32'h0000_0001, 4'h1));
    set_d(1'b0, 1'b0, 32'h3000_0000, 32'h0000_0001, 4'h1);
    bus.dcache_mem_req = 1'b1;
    cyc(2);
    bus.dcache_mem_req = 1'b0;
    cyc(1);
    chk("drop_idle_req", bus.arb_mem_req, 1'b0);
    bus.mem_arb_dataOK = 1'b1;
    bus.mem_arb_addrOK = 1'b1;
    cyc(1);
    bus.mem_arb_dataOK = 1'b0;
    bus.mem_arb_addrOK = 1'b0;
    exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h1C00_0200, 32'd0, 4'd0));
    exp_rsp_q.push_back(mk_rsp(P_I, K_AOK, '0));
    exp_rsp_q.push_back(mk_rsp(P_I, K_DOK, {4{32'h2222_3333}}));
    bus.icache_mem_addr = 32'h1C00_0200;
    bus.icache_mem_req  = 1'b1;
    bus.dcache_mem_req  = 1'b1;
    mem_read(0, 1, {4{32'h2222_3333}});
    bus.icache_mem_req = 1'b0;
    bus.dcache_mem_req = 1'b0;
    cyc(1);

    // Read with addrOK and dataOK in the same cycle
    exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h3000_0080, 32'h0000_0002, 4'h2));
    exp_rsp_q.push_back(mk_rsp(P_D, K_AOK, '0));
    exp_rsp_q.push_back(mk_rsp(P_D, K_DOK, {4{32'h4444_5555}}));
    set_d(1'b0, 1'b0, 32'h3000_0080, 32'h0000_0002, 4'h2);
    bus.dcache_mem_req = 1'b1;
    mem_read_same(1, {4{32'h4444_5555}});
    bus.dcache_mem_req = 1'b0;
    chk("same_idle_req", bus.arb_mem_req, 1'b0);
    cyc(1);

    // Reset in WDATA: outputs clear, late dataOK dropped, next tie to D
    exp_req_q.push_back(mk_req(1'b0, 1'b0, 32'h3000_00C0, 32'h0000_0003, 4'h4));
    exp_rsp_q.push_back(mk_rsp(P_D, K_AOK, '0));
    set_d(1'b0, 1'b0, 32'h3000_00C0, 32'h0000_0003, 4'h4);
    bus.dcache_mem_req = 1'b1;
    cyc(1);
    bus.mem_arb_addrOK = 1'b1;
    cyc(1);
    bus.mem_arb_addrOK = 1'b0;
    rstn = 1'b0;
    bus.dcache_mem_req = 1'b0;
    cyc(1);
    chk_all_zero("midrst");
    rstn = 1'b1;
    cyc(1);
    bus.mem_arb_dataOK = 1'b1;
    cyc(1);
    bus.mem_arb_dataOK = 1'b0;
    exp_req_q.push_back(mk_req(1'b1, 1'b0, 32'h1000_0008, 32'h55AA_55AA, 4'h5));
    exp_rsp_q.push_back(mk_rsp(P_D, K_AOK, '0));
    set_d(1'b1, 1'b0, 32'h1000_0008, 32'h55AA_55AA, 4'h5);
    bus.icache_mem_addr = 32'h1C00_0300;
    bus.dcache_mem_req  = 1'b1;
    bus.icache_mem_req  = 1'b1;
    mem_write(1);
    bus.dcache_mem_req = 1'b0;
    bus.icache_mem_req = 1'b0;
    cyc(3);

    chk("req_queue_drained", 128'(exp_req_q.size()), 128'd0);
    chk("rsp_queue_drained", 128'(exp_rsp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
